if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction prefetch stage directly upstream of IF/ID. Issues in-order fetches to
//  instruction memory over a valid/ready request channel, buffers returned words with PC,
//  and presents them to IF/ID through a valid/ready dequeue port.
//  A branch redirect (PCSrcD/PCBranchD) flushes the queue and squashes in-flight responses.
// PARAMETERS
//  DEPTH     4             queue entries; also caps fetches in flight (power of 2, >=2)
//  ADDR_W    32            PC / memory address width
//  DATA_W    32            instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  redirect_valid  in   1       branch taken in ID (PCSrcD)
//  redirect_pc     in   ADDR_W  branch target (PCBranchD); bits [1:0] ignored
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request this cycle
//  imem_req_addr   out  ADDR_W  word-aligned fetch address
//  imem_rsp_valid  in   1       response beat; in order, >=1 cycle after acceptance, no backpressure
//  imem_rsp_data   in   DATA_W  instruction word
//  deq_valid       out  1       head entry available
//  deq_ready       in   1       IF/ID takes head (~StallD)
//  deq_instr       out  DATA_W  head instruction
//  deq_pc          out  ADDR_W  head PC
//  deq_pc_plus4    out  ADDR_W  head PC + 4 (mod 2^ADDR_W)
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, count=0, outstanding=0, drop_cnt=0; imem_req_valid=0,
//    deq_valid=0, deq_instr/deq_pc/deq_pc_plus4=0, imem_req_addr=RESET_PC.
//    Reset mid-operation discards all entries and in-flight fetches.
//  - Request: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH); addr = fetch_pc.
//    On accept: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0), outstanding++.
//  - Response: outstanding--. If drop_cnt!=0: discarded, drop_cnt--. Else written at tail
//    with its PC (pc_tag FIFO parallel to data). Reservation guarantees no overflow.
//    Response with outstanding==0 is a protocol error: ignored, assertion fires.
//  - Dequeue: deq_valid = (count!=0); pop on deq_valid && deq_ready. Outputs are registered
//    head; no bypass: response in cycle N -> deq_valid earliest cycle N+1.
//  - Simultaneous push+pop: count unchanged; legal at count==DEPTH-... any occupancy.
//  - Redirect (highest priority): next cycle count=0, deq_valid=0,
//    fetch_pc={redirect_pc[ADDR_W-1:2],2'b00}, drop_cnt = outstanding_next (in-flight minus any
//    response arriving this cycle, which itself is discarded). No request offered in redirect cycle;
//    deq pop in the redirect cycle still completes. Requests resume next cycle while drop_cnt drains.
//  - Back-to-back redirects: second overrides; drop_cnt recomputed from current outstanding.
//  - FSM (2 states): RUN (drop_cnt==0) <-> SQUASH (drop_cnt!=0); RUN->SQUASH on redirect with
//    outstanding_next!=0; SQUASH->RUN when last stale response retired.
//  - Counters: count, outstanding, drop_cnt are $clog2(DEPTH+1) bits; never exceed DEPTH.
// STRUCTURE
//  - mips_pkg: ADDR_W/DATA_W defaults, RESET_PC, PC_STEP=4, prefetch entry struct {pc, instr}.
//  - Sub-module prefetch_fifo: synchronous DEPTH-entry FIFO with flush, push, pop, count.
//    Top holds fetch_pc, outstanding/drop counters, squash FSM, request logic.
// TESTING
//  1 Reset release, ready=1, 1-cycle memory: requests 0x0,0x4,0x8,0xC; deq_pc 0x0 valid 2 cycles
//    after first accept; stream in order with deq_pc_plus4 = deq_pc+4.
//  2 deq_ready=0: exactly 4 requests issued then imem_req_valid=0; one pop -> one new request next cycle.
//  3 3-cycle memory latency, redirect_pc=0x100 with 3 in flight: 3 stale responses dropped,
//    first deq_pc=0x100, no stale PC ever dequeued.
//  4 Redirect in same cycle as response and pop: popped entry consumed, response dropped,
//    drop_cnt = remaining in-flight, deq_valid=0 next cycle.
//  5 redirect_pc=0xFFFF_FFFE: fetches 0xFFFF_FFFC then 0x0000_0000; deq_pc_plus4=0 at wrap.
//  6 rst_n low mid-stream with 2 in flight: outputs at reset values immediately; after release
//    first request addr=RESET_PC; bench suppresses old responses, queue stays empty.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Entry layout and default widths live here so the FIFO and the top agree on them.
package if_prefetch_queue_pkg;

  localparam int PKG_DEPTH  = 4;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam logic [PKG_ADDR_W-1:0] PKG_RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } squashState_e;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] pc;
    logic [PKG_DATA_W-1:0] instr;
  } prefetchEntry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bundle of the redirect, instruction-memory and dequeue signals of the prefetch queue.
// master = the prefetch queue itself, slave = the surrounding pipeline/memory.
interface if_prefetch_queue_if
  import if_prefetch_queue_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int DATA_W = PKG_DATA_W
) ();

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_instr;
  logic [ADDR_W-1:0] deq_pc;
  logic [ADDR_W-1:0] deq_pc_plus4;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, deq_ready,
    output imem_req_valid, imem_req_addr, deq_valid, deq_instr, deq_pc, deq_pc_plus4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, deq_ready,
    input  imem_req_valid, imem_req_addr, deq_valid, deq_instr, deq_pc, deq_pc_plus4
  );

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} with flush; head is read straight from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_prefetch_queue_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = PKG_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           push,
  input  logic           pop,
  input  prefetchEntry_t pushEntry,
  output prefetchEntry_t headEntry,
  output logic [CW-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  prefetchEntry_t mem [DEPTH];
  logic [PW-1:0]  wrPtr;
  logic [PW-1:0]  rdPtr;
  logic           doPush;
  logic           doPop;

  assign doPush = push && !flush;
  assign doPop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  assign headEntry = mem[rdPtr];

endmodule

// File: rtl/if_prefetch_queue.sv
// In-order instruction prefetch queue feeding IF/ID, with branch-redirect flush and squash of
// responses still in flight when the redirect happens.
//
//   state  | meaning
//   RUN    | no stale fetches outstanding; every response is queued
//   SQUASH | dropCnt stale responses still due; each one is discarded on arrival
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = PKG_DEPTH,
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int DATA_W = PKG_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = PKG_RESET_PC
) (
  input logic clk,
  input logic rst_n,
  if_prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  squashState_e      state;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] rspPc;
  logic [ADDR_W-1:0] targetPc;
  logic [DATA_W-1:0] rspData;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outNext;
  logic [CW-1:0]     dropCnt;
  logic [CW:0]       reserved;
  logic              reqValid;
  logic              reqFire;
  logic              rspFire;
  logic              dropRsp;
  logic              keepRsp;
  logic              pop;
  prefetchEntry_t    pushEntry;
  prefetchEntry_t    headEntry;

  // Queued words plus fetches in flight never exceed DEPTH, so a response always has a slot.
  assign reserved = {1'b0, count} + {1'b0, outstanding};
  assign reqValid = rst_n && !bus.redirect_valid && (reserved < DEPTH_C);
  assign reqFire  = reqValid && bus.imem_req_ready;
  assign rspFire  = bus.imem_rsp_valid && (outstanding != '0);
  assign dropRsp  = rspFire && (bus.redirect_valid || state == SQUASH);
  assign keepRsp  = rspFire && !dropRsp;
  assign pop      = bus.deq_valid && bus.deq_ready;
  assign outNext  = outstanding + {{(CW-1){1'b0}}, reqFire} - {{(CW-1){1'b0}}, rspFire};
  assign targetPc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign rspData  = bus.imem_rsp_data;

  // Responses come back in order and fetches are sequential, so the next kept response's PC
  // is tracked with a single register instead of a tag per in-flight request.
  assign pushEntry.pc    = rspPc;
  assign pushEntry.instr = rspData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      dropCnt     <= '0;
      outstanding <= '0;
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
    end else begin
      outstanding <= outNext;
      if (bus.redirect_valid) begin
        fetchPc <= targetPc;
        rspPc   <= targetPc;
        dropCnt <= outNext;
        state   <= (outNext != '0) ? SQUASH : RUN;
      end else begin
        if (reqFire) fetchPc <= fetchPc + STEP;
        if (keepRsp) rspPc   <= rspPc + STEP;
        if (dropRsp) begin
          dropCnt <= dropCnt - 1'b1;
          state   <= (dropCnt == CW'(1)) ? RUN : SQUASH;
        end
      end
    end
  end

  if_prefetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (keepRsp),
    .pop       (pop),
    .pushEntry (pushEntry),
    .headEntry (headEntry),
    .count     (count)
  );

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc;
  assign bus.deq_valid      = (count != '0);
  assign bus.deq_instr      = bus.deq_valid ? headEntry.instr : '0;
  assign bus.deq_pc         = bus.deq_valid ? headEntry.pc : '0;
  assign bus.deq_pc_plus4   = bus.deq_valid ? headEntry.pc + STEP : '0;

  rspWithoutFetch: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios against a queue-based reference model,
// plus literal expectations for the key scenario milestones.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct { logic [31:0] pc; bit stale; } inFlight_t;
  typedef struct { int due; logic [31:0] data; } memBeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_queue_if b ();

  if_prefetch_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int checks = 0;
  int failures = 0;
  int cycNum = 0;
  int lat = 1;
  int firstAcc = -1;
  int firstDv = -1;

  logic [31:0] mPc;
  logic [31:0] mq[$];
  inFlight_t   fl[$];
  memBeat_t    memQ[$];
  logic [31:0] reqLog[$];
  logic [31:0] popLog[$];
  logic [31:0] popP4[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy, input logic dqr);
    logic      rspNow;
    logic      expReqValid;
    logic      expPop;
    inFlight_t e;
    @(negedge clk);
    b.redirect_valid = redir;
    b.redirect_pc    = rpc;
    b.imem_req_ready = rdy;
    b.deq_ready      = dqr;
    rspNow = (memQ.size() != 0) && (memQ[0].due <= cycNum);
    b.imem_rsp_valid = rspNow;
    b.imem_rsp_data  = rspNow ? memQ[0].data : 32'h0;
    #1;
    expReqValid = !redir && (mq.size() + fl.size() < DEPTH);
    expPop      = (mq.size() != 0) && dqr;
    chkBit("req_valid", b.imem_req_valid, expReqValid);
    chk("req_addr", b.imem_req_addr, mPc);
    chkBit("deq_valid", b.deq_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("deq_pc", b.deq_pc, mq[0]);
      chk("deq_instr", b.deq_instr, memData(mq[0]));
      chk("deq_pc_plus4", b.deq_pc_plus4, mq[0] + 32'd4);
    end
    if (b.deq_valid && firstDv < 0) firstDv = cycNum;
    if (b.deq_valid && dqr) begin
      popLog.push_back(b.deq_pc);
      popP4.push_back(b.deq_pc_plus4);
    end
    // memory side reacts to what the DUT actually does
    if (rspNow) void'(memQ.pop_front());
    if (b.imem_req_valid && rdy) begin
      memQ.push_back('{cycNum + lat, memData(b.imem_req_addr)});
      reqLog.push_back(b.imem_req_addr);
      if (firstAcc < 0) firstAcc = cycNum;
    end
    // model update
    if (expPop) void'(mq.pop_front());
    if (rspNow && fl.size() != 0) begin
      e = fl.pop_front();
      if (!e.stale && !redir) mq.push_back(e.pc);
    end
    if (redir) begin
      mq.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
      mPc = rpc & 32'hFFFF_FFFC;
    end else if (expReqValid && rdy) begin
      fl.push_back('{mPc, 1'b0});
      mPc = mPc + 32'd4;
    end
    cycNum++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    b.redirect_valid = 1'b0;
    b.redirect_pc    = 32'h0;
    b.imem_req_ready = 1'b0;
    b.imem_rsp_valid = 1'b0;
    b.imem_rsp_data  = 32'h0;
    b.deq_ready      = 1'b0;
    #1;
    chkBit("rst_req_valid", b.imem_req_valid, 1'b0);
    chk("rst_req_addr", b.imem_req_addr, 32'h0);
    chkBit("rst_deq_valid", b.deq_valid, 1'b0);
    chk("rst_deq_instr", b.deq_instr, 32'h0);
    chk("rst_deq_pc", b.deq_pc, 32'h0);
    chk("rst_deq_pc_plus4", b.deq_pc_plus4, 32'h0);
    memQ.delete();
    mq.delete();
    fl.delete();
    reqLog.delete();
    popLog.delete();
    popP4.delete();
    mPc = 32'h0;
    firstAcc = -1;
    firstDv = -1;
    cycNum = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int stale;
    int n0;

    // 1: streaming with 1-cycle memory
    lat = 1;
    doReset();
    repeat (12) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t1_req0", reqLog[0], 32'h0);
    chk("t1_req1", reqLog[1], 32'h4);
    chk("t1_req2", reqLog[2], 32'h8);
    chk("t1_req3", reqLog[3], 32'hC);
    chk("t1_first_deq_lat", 32'(firstDv - firstAcc), 32'd2);
    chk("t1_pop0", popLog[0], 32'h0);
    chk("t1_pop1_plus4", popP4[1], 32'h8);

    // 2: consumer stalled, reservation caps requests at DEPTH
    doReset();
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_req_count", 32'(reqLog.size()), 32'd4);
    chkBit("t2_req_valid_full", b.imem_req_valid, 1'b0);
    n0 = reqLog.size();
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_req_after_pop", 32'(reqLog.size() - n0), 32'd1);

    // 3: redirect with three fetches in flight, 3-cycle memory
    lat = 3;
    doReset();
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h100, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t3_first_pc", popLog[0], 32'h100);
    stale = 0;
    foreach (popLog[i]) if (popLog[i] < 32'h100) stale++;
    chk("t3_stale_pops", 32'(stale), 32'd0);

    // 4: redirect coinciding with a response and a pop
    lat = 2;
    doReset();
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h200, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("t4_drop_cnt", 32'(dut.dropCnt), 32'd1);
    chkBit("t4_deq_valid_after", b.deq_valid, 1'b0);
    chk("t4_popped_in_redirect", popLog[0], 32'h0);
    popLog.delete();
    popP4.delete();
    repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t4_first_pc", popLog[0], 32'h200);

    // 5: redirect to the top of the address space, fetch PC wraps
    lat = 1;
    doReset();
    cyc(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_req0", reqLog[0], 32'hFFFF_FFFC);
    chk("t5_req1", reqLog[1], 32'h0);
    chk("t5_pop0", popLog[0], 32'hFFFF_FFFC);
    chk("t5_pop0_plus4", popP4[0], 32'h0);

    // 6: reset while two fetches are in flight
    lat = 3;
    doReset();
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_inflight", 32'(fl.size()), 32'd2);
    doReset();
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_req0", reqLog[0], 32'h0);
    chk("t6_pop0", popLog[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
